rtc_burst_reader: RTL and testbench



---
 rtl/rtc_burst_reader.sv | 171 +++++++++++++++++
 tb/tb_rtc_burst_reader.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_burst_reader.sv
// rtc_burst_reader: command write then burst read of RTC registers into a shadow bank, committed atomically
module rtc_burst_reader #(
    parameter int                DATA_W       = 8,
    parameter int                NUM_REGS     = 6,
    parameter int                TMR_REGS     = 3,
    parameter logic [7:0]        CMD_ADDR_CLK = 8'hF1,
    parameter logic [7:0]        CMD_ADDR_TMR = 8'hF2,
    parameter logic [DATA_W-1:0] CMD_DATA     = 1,
    parameter logic [7:0]        BASE_CLK     = 8'h21,
    parameter logic [7:0]        BASE_TMR     = 8'h41,
    parameter int                TIMEOUT      = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       mode,
    input  logic                       abort,
    output logic                       cyc_req,
    output logic                       cyc_wr,
    output logic [7:0]                 cyc_addr,
    output logic [DATA_W-1:0]          cyc_wdata,
    input  logic                       cyc_ack,
    input  logic [DATA_W-1:0]          cyc_rdata,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic                       busy,
    output logic                       done,
    output logic [NUM_REGS-1:0]        bcd_err,
    output logic                       timeout_err
);
    localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, CMD, GAP, RD} state_t;

    state_t                          state_q, state_d;
    logic                            mode_q, mode_d;
    logic [IW-1:0]                   idx_q, idx_d;
    logic [TW-1:0]                   tmo_q, tmo_d;
    logic                            cyc_req_q, cyc_req_d, cyc_wr_q, cyc_wr_d;
    logic [7:0]                      cyc_addr_q, cyc_addr_d;
    logic [DATA_W-1:0]               cyc_wdata_q, cyc_wdata_d;
    logic [NUM_REGS-1:0][DATA_W-1:0] shadow_q, shadow_d, regs_q, regs_d;
    logic [NUM_REGS-1:0]             bcd_q, bcd_d;
    logic                            busy_q, busy_d, done_q, done_d, timeout_err_q, timeout_err_d;
    logic [IW:0]                     cnt;
    logic                            last, to_idle;
    logic [7:0]                      rd_addr;

    function automatic logic bad_bcd(input logic [DATA_W-1:0] b);
        bad_bcd = 1'b0;
        for (int n = 0; n < DATA_W / 4; n++) bad_bcd |= (b[n*4 +: 4] > 4'd9);
    endfunction

    always_comb begin
        cnt           = mode_q ? (IW+1)'(TMR_REGS) : (IW+1)'(NUM_REGS);
        last          = ({1'b0, idx_q} == cnt - (IW+1)'(1));
        rd_addr       = (mode_q ? BASE_TMR : BASE_CLK) + 8'(idx_q);
        to_idle       = 1'b0;
        state_d       = state_q;
        mode_d        = mode_q;
        idx_d         = idx_q;
        tmo_d         = tmo_q;
        cyc_req_d     = cyc_req_q;
        cyc_wr_d      = cyc_wr_q;
        cyc_addr_d    = cyc_addr_q;
        cyc_wdata_d   = cyc_wdata_q;
        shadow_d      = shadow_q;
        regs_d        = regs_q;
        bcd_d         = bcd_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        timeout_err_d = timeout_err_q;
        case (state_q)
            IDLE: if (start) begin
                state_d       = CMD;
                mode_d        = mode;
                idx_d         = '0;
                tmo_d         = '0;
                busy_d        = 1'b1;
                timeout_err_d = 1'b0;
                cyc_req_d     = 1'b1;
                cyc_wr_d      = 1'b1;
                cyc_addr_d    = mode ? CMD_ADDR_TMR : CMD_ADDR_CLK;
                cyc_wdata_d   = CMD_DATA;
            end
            GAP: if (abort) to_idle = 1'b1;
            else begin
                state_d    = RD;
                cyc_req_d  = 1'b1;
                cyc_wr_d   = 1'b0;
                cyc_addr_d = rd_addr;
                tmo_d      = '0;
            end
            default: if (cyc_ack) begin
                // The byte lands in the shadow even when the burst is aborted on this ack
                if (state_q == RD)
                    for (int i = 0; i < NUM_REGS; i++) if (i == int'(idx_q)) shadow_d[i] = cyc_rdata;
                if (abort) to_idle = 1'b1;
                else if (state_q == CMD || !last) begin
                    state_d   = GAP;
                    cyc_req_d = 1'b0;
                    idx_d     = state_q == RD ? idx_q + IW'(1) : idx_q;
                end else begin
                    to_idle = 1'b1;
                    done_d  = 1'b1;
                    for (int i = 0; i < NUM_REGS; i++)
                        if (i < int'(cnt)) begin
                            regs_d[i] = shadow_d[i];
                            bcd_d[i]  = bad_bcd(shadow_d[i]);
                        end
                end
            end else if (abort) to_idle = 1'b1;
            else if (tmo_q == TW'(TIMEOUT - 1)) begin
                to_idle       = 1'b1;
                timeout_err_d = 1'b1;
            end else tmo_d = tmo_q + TW'(1);
        endcase
        if (to_idle) begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            cyc_req_d   = 1'b0;
            cyc_wr_d    = 1'b0;
            cyc_addr_d  = 8'hFF;
            cyc_wdata_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            mode_q        <= 1'b0;
            idx_q         <= '0;
            tmo_q         <= '0;
            cyc_req_q     <= 1'b0;
            cyc_wr_q      <= 1'b0;
            cyc_addr_q    <= 8'hFF;
            cyc_wdata_q   <= '0;
            shadow_q      <= '0;
            regs_q        <= '0;
            bcd_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            idx_q         <= idx_d;
            tmo_q         <= tmo_d;
            cyc_req_q     <= cyc_req_d;
            cyc_wr_q      <= cyc_wr_d;
            cyc_addr_q    <= cyc_addr_d;
            cyc_wdata_q   <= cyc_wdata_d;
            shadow_q      <= shadow_d;
            regs_q        <= regs_d;
            bcd_q         <= bcd_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign cyc_req     = cyc_req_q;
    assign cyc_wr      = cyc_wr_q;
    assign cyc_addr    = cyc_addr_q;
    assign cyc_wdata   = cyc_wdata_q;
    assign regs_o      = regs_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign bcd_err     = bcd_q;
    assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_rtc_burst_reader.sv
// tb_rtc_burst_reader: bus-engine responder plus burst-level reference model for rtc_burst_reader
module tb_rtc_burst_reader;
    localparam int TMO = 8;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0, abort = 1'b0;
    logic        cyc_req, cyc_wr, cyc_ack, busy, done, timeout_err;
    logic [7:0]  cyc_addr, cyc_wdata, cyc_rdata;
    logic [47:0] regs_o;
    logic [5:0]  bcd_err;
    logic        resp_ack = 1'b0, inj_ack = 1'b0;
    logic [7:0]  inj_data = 8'h00;
    logic [7:0]  mem [256];
    int          wait_tbl [256];
    logic [16:0] log_q [$];
    int          stab_err = 0;
    int          checks = 0, errors = 0;
    logic [7:0]  mregs [6];
    logic [5:0]  mbcd = '0;

    typedef struct {
        bit          m;
        logic [47:0] data;
        logic [47:0] exp_regs;
        logic [5:0]  exp_bcd;
        int          exp_lat;
    } vec_t;
    vec_t tbl [3];

    assign cyc_ack   = resp_ack | inj_ack;
    assign cyc_rdata = resp_ack ? mem[cyc_addr] : inj_data;

    rtc_burst_reader #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .abort(abort),
        .cyc_req(cyc_req), .cyc_wr(cyc_wr), .cyc_addr(cyc_addr), .cyc_wdata(cyc_wdata),
        .cyc_ack(cyc_ack), .cyc_rdata(cyc_rdata), .regs_o(regs_o), .busy(busy),
        .done(done), .bcd_err(bcd_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Bus engine: acks after wait_tbl[addr] idle cycles of a held request, logs each completed cycle
    initial begin
        int          hi;
        logic        prev_req;
        logic [16:0] prev;
        hi = 0;
        prev_req = 1'b0;
        prev = '0;
        forever begin
            @(posedge clk);
            #1;
            if (cyc_req && prev_req && {cyc_wr, cyc_addr, cyc_wdata} != prev) stab_err++;
            prev_req = cyc_req;
            prev = {cyc_wr, cyc_addr, cyc_wdata};
            if (cyc_req && !resp_ack) begin
                hi++;
                resp_ack = (hi == wait_tbl[cyc_addr] + 1);
                if (resp_ack) log_q.push_back({cyc_wr, cyc_addr, cyc_wdata});
            end else begin
                hi = 0;
                resp_ack = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] mpack();
        logic [47:0] r;
        for (int i = 0; i < 6; i++) r[i*8 +: 8] = mregs[i];
        return r;
    endfunction

    task automatic predict(input bit m, output int lat, output bit ok, output int nacks);
        int         cnt;
        logic [7:0] a;
        cnt = m ? 3 : 6;
        lat = 0;
        ok = 1'b1;
        nacks = 0;
        for (int k = 0; k <= cnt && ok; k++) begin
            a = (k == 0) ? (m ? 8'hF2 : 8'hF1) : (m ? 8'h41 : 8'h21) + 8'(k - 1);
            if (k > 0) lat++;
            if (wait_tbl[a] + 1 > TMO) begin
                lat += TMO;
                ok = 1'b0;
            end else begin
                lat += wait_tbl[a] + 1;
                nacks++;
            end
        end
    endtask

    task automatic model_commit(input bit m);
        int v;
        for (int i = 0; i < (m ? 3 : 6); i++) begin
            v = int'(mem[(m ? 8'h41 : 8'h21) + 8'(i)]);
            mregs[i] = 8'(v);
            mbcd[i] = (v % 16 > 9) || (v / 16 > 9);
        end
    endtask

    task automatic do_burst(input bit m, input bit noisy, output int lat, output int dones);
        start = 1'b1;
        mode = m;
        tick();
        start = 1'b0;
        chk("first req", 64'(cyc_req), 64'(1));
        chk("first wr", 64'(cyc_wr), 64'(1));
        chk("first addr", 64'(cyc_addr), 64'(m ? 8'hF2 : 8'hF1));
        chk("first wdata", 64'(cyc_wdata), 64'(8'h01));
        chk("first busy", 64'(busy), 64'(1));
        chk("terr cleared", 64'(timeout_err), 64'(0));
        lat = 0;
        dones = 0;
        while (lat < 3000) begin
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                mode = 1'($urandom_range(0, 1));
            end
            tick();
            lat++;
            if (done) dones++;
            if (!busy) break;
        end
        start = 1'b0;
        chk("burst ends", 64'(lat < 3000), 64'(1));
    endtask

    task automatic check_burst(input string name, input bit m, input bit noisy, output int lat);
        int   elat, enacks, dones, l0;
        bit   eok;
        predict(m, elat, eok, enacks);
        l0 = log_q.size();
        do_burst(m, noisy, lat, dones);
        if (eok) model_commit(m);
        chk({name, " latency"}, 64'(lat), 64'(elat));
        chk({name, " done count"}, 64'(dones), 64'(eok));
        chk({name, " timeout_err"}, 64'(timeout_err), 64'(!eok));
        chk({name, " regs"}, 64'(regs_o), 64'(mpack()));
        chk({name, " bcd"}, 64'(bcd_err), 64'(mbcd));
        chk({name, " acks"}, 64'(log_q.size() - l0), 64'(enacks));
        if (log_q.size() > l0) chk({name, " cmd cycle"}, 64'(log_q[l0]), 64'({1'b1, m ? 8'hF2 : 8'hF1, 8'h01}));
        for (int k = 1; k < enacks && l0 + k < log_q.size(); k++)
            chk({name, " read addr"}, 64'(log_q[l0 + k][16:8]), 64'({1'b0, (m ? 8'h41 : 8'h21) + 8'(k - 1)}));
        chk({name, " req idle"}, 64'(cyc_req), 64'(0));
        tick();
        chk({name, " done pulse"}, 64'(done), 64'(0));
        chk({name, " idle addr"}, 64'(cyc_addr), 64'(8'hFF));
    endtask

    task automatic wait_req_addr(input logic [7:0] a, input string name);
        int n = 0;
        while (!(cyc_req && cyc_addr == a) && n < 200) begin
            tick();
            n++;
        end
        chk({name, " reached"}, 64'(n < 200), 64'(1));
    endtask

    initial begin
        int          lat, seen_done, n;
        logic [47:0] keep;
        bit          m;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
            wait_tbl[i] = 2;
        end
        for (int i = 0; i < 6; i++) mregs[i] = 8'h00;
        tbl[0] = '{1'b0, 48'h16_12_31_23_45_59, 48'h16_12_31_23_45_59, 6'b000000, 27};
        tbl[1] = '{1'b1, 48'h00_00_00_03_20_10, 48'h16_12_31_03_20_10, 6'b000000, 15};
        tbl[2] = '{1'b0, 48'h16_12_31_23_6A_59, 48'h16_12_31_23_6A_59, 6'b000010, 27};

        tick();
        tick();
        chk("rst req", 64'(cyc_req), 64'(0));
        chk("rst wr", 64'(cyc_wr), 64'(0));
        chk("rst addr", 64'(cyc_addr), 64'(8'hFF));
        chk("rst wdata", 64'(cyc_wdata), 64'(0));
        chk("rst regs", 64'(regs_o), 64'(0));
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst done", 64'(done), 64'(0));
        chk("rst bcd", 64'(bcd_err), 64'(0));
        chk("rst terr", 64'(timeout_err), 64'(0));
        reset = 1'b0;
        tick();

        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < (tbl[v].m ? 3 : 6); i++)
                mem[(tbl[v].m ? 8'h41 : 8'h21) + 8'(i)] = tbl[v].data[i*8 +: 8];
            check_burst("vector", tbl[v].m, 1'b0, lat);
            chk("vector const regs", 64'(regs_o), 64'(tbl[v].exp_regs));
            chk("vector const bcd", 64'(bcd_err), 64'(tbl[v].exp_bcd));
            chk("vector const latency", 64'(lat), 64'(tbl[v].exp_lat));
        end

        wait_tbl[8'h23] = 1000;
        check_burst("timeout", 1'b0, 1'b0, lat);
        chk("timeout const latency", 64'(lat), 64'(20));
        wait_tbl[8'h23] = 2;
        check_burst("after timeout", 1'b0, 1'b0, lat);
        wait_tbl[8'hF1] = TMO - 1;
        check_burst("ack at limit", 1'b0, 1'b0, lat);
        wait_tbl[8'hF1] = TMO;
        check_burst("limit reached", 1'b0, 1'b0, lat);
        wait_tbl[8'hF1] = 2;

        keep = regs_o;
        start = 1'b1;
        mode = 1'b0;
        tick();
        start = 1'b0;
        wait_req_addr(8'h24, "abort rd4");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort req drop", 64'(cyc_req), 64'(0));
        chk("abort busy", 64'(busy), 64'(0));
        seen_done = int'(done);
        repeat (3) begin
            tick();
            seen_done += int'(done);
        end
        chk("abort no done", 64'(seen_done), 64'(0));
        chk("abort regs", 64'(regs_o), 64'(keep));

        for (int i = 0; i < 3; i++) mem[8'h41 + 8'(i)] = 8'h77 + 8'(i);
        start = 1'b1;
        mode = 1'b1;
        tick();
        start = 1'b0;
        wait_req_addr(8'h43, "abort ack");
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort ack busy", 64'(busy), 64'(0));
        chk("abort ack done", 64'(done), 64'(0));
        chk("abort ack regs", 64'(regs_o), 64'(keep));

        start = 1'b1;
        mode = 1'b0;
        tick();
        start = 1'b0;
        n = 0;
        while (!(busy && !cyc_req) && n < 200) begin
            tick();
            n++;
        end
        chk("gap reached", 64'(n < 200), 64'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("gap abort busy", 64'(busy), 64'(0));
        tick();
        chk("gap abort no read", 64'(cyc_req), 64'(0));
        chk("gap abort regs", 64'(regs_o), 64'(keep));

        inj_data = 8'h99;
        inj_ack = 1'b1;
        tick();
        inj_ack = 1'b0;
        tick();
        chk("idle ack busy", 64'(busy), 64'(0));
        chk("idle ack req", 64'(cyc_req), 64'(0));
        chk("idle ack done", 64'(done), 64'(0));
        chk("idle ack regs", 64'(regs_o), 64'(keep));

        for (int r = 0; r < 40; r++) begin
            m = 1'($urandom_range(0, 1));
            wait_tbl[m ? 8'hF2 : 8'hF1] = $urandom_range(0, 3);
            for (int i = 0; i < (m ? 3 : 6); i++) begin
                n = $urandom_range(0, 19);
                mem[(m ? 8'h41 : 8'h21) + 8'(i)] = $urandom_range(0, 1) ?
                    {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))} : 8'($urandom);
                wait_tbl[(m ? 8'h41 : 8'h21) + 8'(i)] = n == 0 ? TMO : n == 1 ? TMO - 1 : $urandom_range(0, 3);
            end
            check_burst("random", m, 1'($urandom_range(0, 1)), lat);
        end
        for (int i = 0; i < 256; i++) wait_tbl[i] = 2;

        start = 1'b1;
        mode = 1'b0;
        tick();
        start = 1'b0;
        wait_req_addr(8'h23, "reset mid");
        #2;
        reset = 1'b1;
        #1;
        chk("mid rst req", 64'(cyc_req), 64'(0));
        chk("mid rst wr", 64'(cyc_wr), 64'(0));
        chk("mid rst addr", 64'(cyc_addr), 64'(8'hFF));
        chk("mid rst wdata", 64'(cyc_wdata), 64'(0));
        chk("mid rst regs", 64'(regs_o), 64'(0));
        chk("mid rst busy", 64'(busy), 64'(0));
        chk("mid rst done", 64'(done), 64'(0));
        chk("mid rst bcd", 64'(bcd_err), 64'(0));
        chk("mid rst terr", 64'(timeout_err), 64'(0));
        for (int i = 0; i < 6; i++) mregs[i] = 8'h00;
        mbcd = '0;
        tick();
        reset = 1'b0;
        tick();
        check_burst("after reset", 1'b1, 1'b0, lat);

        chk("addr stable", 64'(stab_err), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
